// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and the
// beat-count helper used to turn one core request into byte-wide memory accesses.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // The reserved size never reaches ACCESS, so its count is a don't-care.
  function automatic logic [2:0] beats(size_t size);
    case (size)
      SZ_BYTE: beats = 3'd1;
      SZ_HALF: beats = 3'd2;
      SZ_WORD: beats = 3'd4;
      default: beats = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus the byte-wide memory port of the load/store unit.
// The master side is whoever plays both the core and the memory; the slave is the unit.
interface load_store_unit_if #(parameter int ADDR_W = 6);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/lsu_extend.sv
// Turns the big-endian assembly register into the final 32-bit load value,
// keeping the low byte/half and sign- or zero-extending it.
module lsu_extend
  import mem_pkg::*;
(
  input  logic [31:0] asm_i,
  input  size_t       size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = asm_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & asm_i[7]}}, asm_i[7:0]};
      SZ_HALF: rdata_o = {{16{signed_i & asm_i[15]}}, asm_i[15:0]};
      default: rdata_o = asm_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: splits one lw/lh/lhu/lb/lbu/sw/sh/sb request into sequential
// big-endian byte accesses and returns the extended load data through a valid/ready response.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  size_t             size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       asm_q, asm_d;

  logic [2:0]        nBeats;
  logic              lastBeat;
  logic [1:0]        byteIdx;
  logic              reqErr;
  logic [31:0]       extData;

  assign nBeats   = beats(size_q);
  assign lastBeat = ({1'b0, beat_q} == (nBeats - 3'd1));
  // Stores go out MSB first, so the first beat picks the highest byte of the access.
  assign byteIdx  = 2'(nBeats - 3'd1 - {1'b0, beat_q});

  assign reqErr = (bus.req_size == SZ_RSVD) ||
                  ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                  ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  lsu_extend u_extend (
    .asm_i   (asm_q),
    .size_i  (size_q),
    .signed_i(signed_q),
    .rdata_o (extData)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          size_d   = size_t'(bus.req_size);
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          beat_d   = 2'd0;
          asm_d    = 32'd0;
          err_d    = reqErr;
          state_d  = reqErr ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q) asm_d = {asm_q[23:0], bus.mem_rdata};
        beat_d = beat_q + 2'd1;
        if (lastBeat) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      beat_q   <= 2'd0;
      asm_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
      asm_q    <= asm_d;
    end
  end

  // Strobes are pure state decodes so an asynchronous reset kills them instantly.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = (state_q == RESP) && err_q;
    bus.rsp_rdata = ((state_q == RESP) && !err_q && !write_q) ? extData : 32'd0;
    bus.mem_re    = (state_q == ACCESS) && !write_q;
    bus.mem_we    = (state_q == ACCESS) && write_q;
    bus.mem_addr  = (state_q == ACCESS) ? (addr_q + ADDR_W'(beat_q)) : '0;
    bus.mem_wdata = bus.mem_we ? 8'(wdata_q >> {byteIdx, 3'b000}) : 8'd0;
  end

endmodule
